// File: rtl/booth_multiplier_4bit_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_multiplier_4bit_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Booth recoding of the {Qreg[0], q_1} pair.
    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        booth_op_e op;
        case ({q0, q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_4bit_booth_step.sv
// One Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Qreg, q_1}.
module booth_step
    import booth_multiplier_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    output logic [WIDTH:0]   a_nxt_c,
    output logic [WIDTH-1:0] q_nxt_c,
    output logic             q_1_nxt_c
);

    booth_op_e        op;
    logic             add_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_upd;

    always_comb begin
        op      = booth_op(q[0], q_1);
        add_sel = (op == OP_ADD);
        // Shared adder: 1 = add, 0 = subtract; wraps modulo 2^(WIDTH+1).
        sum     = add_sel ? (a + m) : (a - m);
        a_upd   = (op == OP_NOP) ? a : sum;
        {a_nxt_c, q_nxt_c, q_1_nxt_c} = {a_upd[WIDTH], a_upd, q};
    end

endmodule

// File: rtl/booth_multiplier_4bit.sv
// Sequential radix-2 Booth multiplier: start/busy/done handshake,
// WIDTH iterations per product, back-to-back accept from DONE.
module booth_multiplier_4bit
    import booth_multiplier_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load;

    logic [WIDTH:0]     step_a;
    logic [WIDTH-1:0]   step_q;
    logic               step_q1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a_q),
        .m         (m_q),
        .q         (qr_q),
        .q_1       (q1_q),
        .a_nxt_c   (step_a),
        .q_nxt_c   (step_q),
        .q_1_nxt_c (step_q1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            qr_q      <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            qr_q      <= qr_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        qr_d      = qr_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                load = start;
            end
            CALC: begin
                a_d   = step_a;
                qr_d  = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    product_d = {step_a[WIDTH-1:0], step_q};
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                load    = start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Accept a new operation from IDLE or straight out of DONE.
        if (load) begin
            m_d     = {multiplicand[WIDTH-1], multiplicand};
            qr_d    = multiplier;
            a_d     = '0;
            q1_d    = 1'b0;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            state_d = CALC;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier_4bit.sv
// Self-checking bench for booth_multiplier_4bit: vector table, handshake
// corner sequences, mid-operation reset and an exhaustive operand sweep.
module tb_booth_multiplier_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[8];

    booth_multiplier_4bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[7:0];
    endfunction

    // Wait (bounded) for done, counting negedges from the current one.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic sb_compare(input string name);
        logic [7:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done with empty scoreboard, product %0h", name, product);
        end else begin
            e = sb.pop_front();
            chk(name, int'(product), int'(e));
        end
    endtask

    task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                          input logic [7:0] exp, input string name);
        int lat;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        chk({name, "_busy_on"}, int'(busy), 1);
        wait_done(lat);
        chk({name, "_done_seen"}, int'(done), 1);
        chk({name, "_latency"}, lat, 4);
        chk({name, "_busy_off"}, int'(busy), 0);
        if (done) sb_compare({name, "_product"});
        @(negedge clk);
        chk({name, "_done_pulse"}, int'(done), 0);
        chk({name, "_hold"}, int'(product), int'(exp));
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        start = 1'b0;
        multiplicand = 4'h0;
        multiplier = 4'h0;
        rst_n = 1'b0;

        vecs[0] = '{4'h3, 4'h5, 8'h0F, "m3_q5"};
        vecs[1] = '{4'hD, 4'h5, 8'hF1, "mn3_q5"};
        vecs[2] = '{4'h5, 4'hD, 8'hF1, "m5_qn3"};
        vecs[3] = '{4'hD, 4'hD, 8'h09, "mn3_qn3"};
        vecs[4] = '{4'h8, 4'h8, 8'h40, "mn8_qn8"};
        vecs[5] = '{4'h7, 4'h8, 8'hC8, "m7_qn8"};
        vecs[6] = '{4'h8, 4'h7, 8'hC8, "mn8_q7"};
        vecs[7] = '{4'h0, 4'h8, 8'h00, "m0_qn8"};

        repeat (3) @(negedge clk);
        chk("rst_product", int'(product), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].exp, vecs[i].name);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                chk("idle_hold", int'(product), 8'h0F);
                chk("idle_busy", int'(busy), 0);
            end
        end

        // start held high: second operation accepted on the DONE cycle
        @(negedge clk);
        multiplicand = 4'h2;
        multiplier   = 4'h3;
        start        = 1'b1;
        sb.push_back(8'h06);
        @(negedge clk);
        multiplicand = 4'h7;
        multiplier   = 4'h7;
        wait_done(lat);
        chk("held1_latency", lat, 4);
        if (done) sb_compare("held1_product");
        multiplicand = 4'h4;
        multiplier   = 4'h4;
        sb.push_back(8'h10);
        @(negedge clk);
        chk("held2_done_low", int'(done), 0);
        chk("held2_busy", int'(busy), 1);
        multiplicand = 4'h1;
        multiplier   = 4'h1;
        wait_done(lat);
        chk("held2_latency", lat, 4);
        if (done) sb_compare("held2_product");
        start = 1'b0;
        @(negedge clk);
        chk("held2_done_pulse", int'(done), 0);
        chk("held2_idle_busy", int'(busy), 0);

        // start pulses and operand changes during CALC are ignored
        @(negedge clk);
        multiplicand = 4'hD;
        multiplier   = 4'h5;
        start        = 1'b1;
        sb.push_back(8'hF1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        multiplicand = 4'h7;
        multiplier   = 4'h7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ign_latency", lat, 2);
        if (done) sb_compare("ign_product");
        @(negedge clk);
        chk("ign_done_pulse", int'(done), 0);
        chk("ign_busy", int'(busy), 0);

        // asynchronous reset during the second CALC cycle of 6*7
        @(negedge clk);
        multiplicand = 4'h6;
        multiplier   = 4'h7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'h6, 4'h7, 8'h2A, "after_rst");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), ref_mul(4'(i), 4'(j)), "exh");
            end
        end

        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
